// File: rtl/ro_buffer_pkg.sv
// ro_buffer_pkg
// Shared types for the reorder buffer: register value / register id / tag
// widths, the usable slot count, and the run/flush state encoding.
package ro_buffer_pkg;

    localparam int RO_BUFFER_SIZE = 15;
    localparam int REG_W          = 32;
    localparam int REG_ID_W       = 5;
    localparam int ROB_ID_W       = 4;

    typedef logic [REG_W-1:0]    reg_t;
    typedef logic [REG_ID_W-1:0] reg_id_t;
    typedef logic [ROB_ID_W-1:0] rob_id_t;

    typedef enum logic {
        ST_RUN   = 1'b0,
        ST_FLUSH = 1'b1
    } rob_state_e;

endpackage

// File: rtl/ro_buffer.sv
// ro_buffer
// Reorder buffer between the issuer, the completion bus and reg_file.
// Allocates tags 1..15 in a circular queue, captures completions, answers
// operand lookups (with same-cycle completion bypass), retires one entry per
// cycle in program order and raises a one-cycle flush on a mispredicted branch.
//
// Ports
//   clk, rst (sync, active high), rdy (global enable)
//   issuer  : valid/rd/is_branch/pred_taken/alt_pc in, dest/full out,
//             qj/qk in, ready_j/k and value_j/k out (combinational)
//   cdb     : valid/dest/value/taken in
//   reg_file: dest/rd/value out (registered, 0 when idle)
//   flush   : reset_to_rob_bus, pc_to_fetcher out (registered)
//
// state | meaning
// RUN   | normal issue / complete / commit
// FLUSH | one cycle after a mispredicted commit: drop everything, pulse flush
module ro_buffer
    import ro_buffer_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        rdy,

    input  logic        valid_from_issuer,
    input  reg_id_t     rd_from_issuer,
    input  logic        is_branch_from_issuer,
    input  logic        pred_taken_from_issuer,
    input  logic [31:0] alt_pc_from_issuer,
    output rob_id_t     dest_to_issuer,
    output logic        full_to_issuer,

    input  rob_id_t     qj_from_issuer,
    input  rob_id_t     qk_from_issuer,
    output logic        ready_j_to_issuer,
    output logic        ready_k_to_issuer,
    output reg_t        value_j_to_issuer,
    output reg_t        value_k_to_issuer,

    input  logic        valid_from_cdb,
    input  rob_id_t     dest_from_cdb,
    input  reg_t        value_from_cdb,
    input  logic        taken_from_cdb,

    output rob_id_t     dest_to_reg_file,
    output reg_id_t     rd_to_reg_file,
    output reg_t        value_to_reg_file,

    output logic        reset_to_rob_bus,
    output logic [31:0] pc_to_fetcher
);

    // Slot 0 exists only so tags index the arrays directly; it is never written.
    logic [15:0] busy_q;
    logic [15:0] ready_q;
    logic [15:0] is_branch_q;
    logic [15:0] pred_q;
    logic [15:0] taken_q;
    reg_id_t     rd_q     [16];
    reg_t        value_q  [16];
    logic [31:0] alt_pc_q [16];

    rob_id_t     head_q, head_d;
    rob_id_t     tail_q, tail_d;
    logic [3:0]  count_q, count_d;
    rob_state_e  state_q;
    logic [31:0] flush_pc_q;

    rob_id_t     dest_out_q;
    reg_id_t     rd_out_q;
    reg_t        value_out_q;
    logic        reset_bus_q;
    logic [31:0] pc_q;

    logic flushing, full, do_issue, do_commit, do_cdb, mispredict;

    function automatic rob_id_t next_ptr(input rob_id_t p);
        return (p == 4'd15) ? 4'd1 : p + 4'd1;
    endfunction

    always_comb begin
        flushing   = (state_q == ST_FLUSH);
        full       = (count_q == 4'd15) || flushing;
        do_issue   = valid_from_issuer && !full;
        do_commit  = (count_q != 4'd0) && ready_q[head_q] && !flushing;
        do_cdb     = valid_from_cdb && !flushing && busy_q[dest_from_cdb];
        mispredict = do_commit && is_branch_q[head_q] &&
                     (taken_q[head_q] != pred_q[head_q]);

        head_d  = do_commit ? next_ptr(head_q) : head_q;
        tail_d  = do_issue  ? next_ptr(tail_q) : tail_q;
        count_d = count_q;
        if (do_issue && !do_commit)
            count_d = count_q + 4'd1;
        else if (!do_issue && do_commit)
            count_d = count_q - 4'd1;
    end

    // Operand lookup: a same-cycle completion wins over the stored value.
    always_comb begin
        ready_j_to_issuer = 1'b0;
        value_j_to_issuer = '0;
        if (qj_from_issuer != 4'd0) begin
            if (valid_from_cdb && dest_from_cdb == qj_from_issuer) begin
                ready_j_to_issuer = 1'b1;
                value_j_to_issuer = value_from_cdb;
            end else if (busy_q[qj_from_issuer] && ready_q[qj_from_issuer]) begin
                ready_j_to_issuer = 1'b1;
                value_j_to_issuer = value_q[qj_from_issuer];
            end
        end

        ready_k_to_issuer = 1'b0;
        value_k_to_issuer = '0;
        if (qk_from_issuer != 4'd0) begin
            if (valid_from_cdb && dest_from_cdb == qk_from_issuer) begin
                ready_k_to_issuer = 1'b1;
                value_k_to_issuer = value_from_cdb;
            end else if (busy_q[qk_from_issuer] && ready_q[qk_from_issuer]) begin
                ready_k_to_issuer = 1'b1;
                value_k_to_issuer = value_q[qk_from_issuer];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            busy_q      <= '0;
            head_q      <= 4'd1;
            tail_q      <= 4'd1;
            count_q     <= 4'd0;
            state_q     <= ST_RUN;
            flush_pc_q  <= '0;
            dest_out_q  <= '0;
            rd_out_q    <= '0;
            value_out_q <= '0;
            reset_bus_q <= 1'b0;
            pc_q        <= '0;
        end else if (rdy) begin
            case (state_q)
                ST_RUN: begin
                    if (do_cdb) begin
                        ready_q[dest_from_cdb] <= 1'b1;
                        value_q[dest_from_cdb] <= value_from_cdb;
                        taken_q[dest_from_cdb] <= taken_from_cdb;
                    end
                    // An issued slot is never busy, so it cannot collide with do_cdb.
                    if (do_issue) begin
                        busy_q[tail_q]      <= 1'b1;
                        ready_q[tail_q]     <= 1'b0;
                        rd_q[tail_q]        <= rd_from_issuer;
                        is_branch_q[tail_q] <= is_branch_from_issuer;
                        pred_q[tail_q]      <= pred_taken_from_issuer;
                        alt_pc_q[tail_q]    <= alt_pc_from_issuer;
                    end
                    if (do_commit) begin
                        busy_q[head_q] <= 1'b0;
                        dest_out_q     <= head_q;
                        rd_out_q       <= rd_q[head_q];
                        value_out_q    <= value_q[head_q];
                    end else begin
                        dest_out_q     <= '0;
                        rd_out_q       <= '0;
                        value_out_q    <= '0;
                    end
                    if (mispredict) begin
                        state_q    <= ST_FLUSH;
                        flush_pc_q <= alt_pc_q[head_q];
                    end
                    head_q      <= head_d;
                    tail_q      <= tail_d;
                    count_q     <= count_d;
                    reset_bus_q <= 1'b0;
                end
                ST_FLUSH: begin
                    busy_q      <= '0;
                    head_q      <= 4'd1;
                    tail_q      <= 4'd1;
                    count_q     <= 4'd0;
                    dest_out_q  <= '0;
                    rd_out_q    <= '0;
                    value_out_q <= '0;
                    reset_bus_q <= 1'b1;
                    pc_q        <= flush_pc_q;
                    state_q     <= ST_RUN;
                end
                default: state_q <= ST_RUN;
            endcase
        end
    end

    assign dest_to_issuer    = tail_q;
    assign full_to_issuer    = full;
    assign dest_to_reg_file  = dest_out_q;
    assign rd_to_reg_file    = rd_out_q;
    assign value_to_reg_file = value_out_q;
    assign reset_to_rob_bus  = reset_bus_q;
    assign pc_to_fetcher     = pc_q;

endmodule

// File: tb/tb_ro_buffer.sv
// tb_ro_buffer
// Directed table, hand-written corner sequences, then randomized traffic
// checked against a queue-based model of the reorder buffer.
module tb_ro_buffer;

    logic        clk = 1'b0;
    logic        rst, rdy;
    logic        valid_from_issuer;
    logic [4:0]  rd_from_issuer;
    logic        is_branch_from_issuer, pred_taken_from_issuer;
    logic [31:0] alt_pc_from_issuer;
    logic [3:0]  dest_to_issuer;
    logic        full_to_issuer;
    logic [3:0]  qj_from_issuer, qk_from_issuer;
    logic        ready_j_to_issuer, ready_k_to_issuer;
    logic [31:0] value_j_to_issuer, value_k_to_issuer;
    logic        valid_from_cdb;
    logic [3:0]  dest_from_cdb;
    logic [31:0] value_from_cdb;
    logic        taken_from_cdb;
    logic [3:0]  dest_to_reg_file;
    logic [4:0]  rd_to_reg_file;
    logic [31:0] value_to_reg_file;
    logic        reset_to_rob_bus;
    logic [31:0] pc_to_fetcher;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    ro_buffer dut (
        .clk(clk), .rst(rst), .rdy(rdy),
        .valid_from_issuer(valid_from_issuer),
        .rd_from_issuer(rd_from_issuer),
        .is_branch_from_issuer(is_branch_from_issuer),
        .pred_taken_from_issuer(pred_taken_from_issuer),
        .alt_pc_from_issuer(alt_pc_from_issuer),
        .dest_to_issuer(dest_to_issuer),
        .full_to_issuer(full_to_issuer),
        .qj_from_issuer(qj_from_issuer),
        .qk_from_issuer(qk_from_issuer),
        .ready_j_to_issuer(ready_j_to_issuer),
        .ready_k_to_issuer(ready_k_to_issuer),
        .value_j_to_issuer(value_j_to_issuer),
        .value_k_to_issuer(value_k_to_issuer),
        .valid_from_cdb(valid_from_cdb),
        .dest_from_cdb(dest_from_cdb),
        .value_from_cdb(value_from_cdb),
        .taken_from_cdb(taken_from_cdb),
        .dest_to_reg_file(dest_to_reg_file),
        .rd_to_reg_file(rd_to_reg_file),
        .value_to_reg_file(value_to_reg_file),
        .reset_to_rob_bus(reset_to_rob_bus),
        .pc_to_fetcher(pc_to_fetcher)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        valid_from_issuer      = 1'b0;
        rd_from_issuer         = '0;
        is_branch_from_issuer  = 1'b0;
        pred_taken_from_issuer = 1'b0;
        alt_pc_from_issuer     = '0;
        qj_from_issuer         = '0;
        qk_from_issuer         = '0;
        valid_from_cdb         = 1'b0;
        dest_from_cdb          = '0;
        value_from_cdb         = '0;
        taken_from_cdb         = 1'b0;
    endtask

    task automatic do_reset();
        idle_inputs();
        rdy = 1'b1;
        rst = 1'b1;
        cyc();
        cyc();
        rst = 1'b0;
    endtask

    task automatic chk_commit(input string name, input logic [3:0] d,
                              input logic [4:0] r, input logic [31:0] v);
        chk({name, ".dest"},  {28'd0, dest_to_reg_file}, {28'd0, d});
        chk({name, ".rd"},    {27'd0, rd_to_reg_file},   {27'd0, r});
        chk({name, ".value"}, value_to_reg_file, v);
    endtask

    // ---------------- directed table ----------------
    typedef struct {
        logic        iv;
        logic [4:0]  rd;
        logic        cv;
        logic [3:0]  cd;
        logic [31:0] cval;
        logic [3:0]  qj;
        logic        exp_rj;
        logic [31:0] exp_vj;
        logic [3:0]  exp_diss;
        logic [3:0]  exp_cdest;
        logic [4:0]  exp_crd;
        logic [31:0] exp_cval;
    } vec_t;

    vec_t tbl [14];

    // ---------------- reference model ----------------
    typedef struct {
        logic [3:0]  tag;
        logic [4:0]  rd;
        logic [31:0] val;
        logic        done;
        logic        br;
        logic        pred;
        logic        tkn;
        logic [31:0] alt;
    } ent_t;

    ent_t        rob [$];
    logic [3:0]  m_next;
    logic        m_pend;
    logic [31:0] m_alt;
    logic [3:0]  m_cdest;
    logic [4:0]  m_crd;
    logic [31:0] m_cval;
    logic        m_rbus;
    logic [31:0] m_pc;

    task automatic model_reset();
        rob.delete();
        m_next = 4'd1;
        m_pend = 1'b0;
        m_alt  = '0;
        m_cdest = '0; m_crd = '0; m_cval = '0;
        m_rbus = 1'b0;
        m_pc   = '0;
    endtask

    task automatic model_lookup(input logic [3:0] q, output logic r, output logic [31:0] v);
        r = 1'b0;
        v = '0;
        if (q != 4'd0) begin
            if (valid_from_cdb && dest_from_cdb == q) begin
                r = 1'b1;
                v = value_from_cdb;
            end else begin
                foreach (rob[i])
                    if (rob[i].tag == q && rob[i].done) begin
                        r = 1'b1;
                        v = rob[i].val;
                    end
            end
        end
    endtask

    task automatic model_edge();
        ent_t e;
        logic commit, issue;
        if (rst) begin
            model_reset();
        end else if (rdy) begin
            if (m_pend) begin
                rob.delete();
                m_next = 4'd1;
                m_pend = 1'b0;
                m_rbus = 1'b1;
                m_pc   = m_alt;
                m_cdest = '0; m_crd = '0; m_cval = '0;
            end else begin
                commit = (rob.size() > 0) && rob[0].done;
                issue  = valid_from_issuer && (rob.size() < 15);
                m_rbus = 1'b0;
                if (commit) begin
                    m_cdest = rob[0].tag;
                    m_crd   = rob[0].rd;
                    m_cval  = rob[0].val;
                    if (rob[0].br && rob[0].tkn != rob[0].pred) begin
                        m_pend = 1'b1;
                        m_alt  = rob[0].alt;
                    end
                end else begin
                    m_cdest = '0; m_crd = '0; m_cval = '0;
                end
                if (valid_from_cdb)
                    foreach (rob[i])
                        if (rob[i].tag == dest_from_cdb) begin
                            rob[i].done = 1'b1;
                            rob[i].val  = value_from_cdb;
                            rob[i].tkn  = taken_from_cdb;
                        end
                if (commit) void'(rob.pop_front());
                if (issue) begin
                    e.tag  = m_next;
                    e.rd   = rd_from_issuer;
                    e.val  = '0;
                    e.done = 1'b0;
                    e.br   = is_branch_from_issuer;
                    e.pred = pred_taken_from_issuer;
                    e.tkn  = 1'b0;
                    e.alt  = alt_pc_from_issuer;
                    rob.push_back(e);
                    m_next = (m_next == 4'd15) ? 4'd1 : m_next + 4'd1;
                end
            end
        end
    endtask

    initial begin
        logic        er, ek;
        logic [31:0] ev, evk;
        int          idx;

        rst = 1'b1;
        rdy = 1'b1;
        idle_inputs();

        // reset then idle
        do_reset();
        chk("reset.dest_to_issuer", {28'd0, dest_to_issuer}, 32'd1);
        chk("reset.full", {31'd0, full_to_issuer}, 32'd0);
        chk_commit("reset", 4'd0, 5'd0, 32'd0);
        chk("reset.flush", {31'd0, reset_to_rob_bus}, 32'd0);
        chk("reset.pc", pc_to_fetcher, 32'd0);

        // basic commit, bypass lookup, out-of-order completion
        tbl[0]  = '{1'b1, 5'd5, 1'b0, 4'd0, 32'h0,    4'd0, 1'b0, 32'h0,    4'd1, 4'd0, 5'd0, 32'h0};
        tbl[1]  = '{1'b0, 5'd0, 1'b1, 4'd1, 32'h1234, 4'd1, 1'b1, 32'h1234, 4'd2, 4'd0, 5'd0, 32'h0};
        tbl[2]  = '{1'b0, 5'd0, 1'b0, 4'd0, 32'h0,    4'd1, 1'b1, 32'h1234, 4'd2, 4'd1, 5'd5, 32'h1234};
        tbl[3]  = '{1'b0, 5'd0, 1'b0, 4'd0, 32'h0,    4'd1, 1'b0, 32'h0,    4'd2, 4'd0, 5'd0, 32'h0};
        tbl[4]  = '{1'b1, 5'd7, 1'b0, 4'd0, 32'h0,    4'd0, 1'b0, 32'h0,    4'd2, 4'd0, 5'd0, 32'h0};
        tbl[5]  = '{1'b1, 5'd8, 1'b0, 4'd0, 32'h0,    4'd0, 1'b0, 32'h0,    4'd3, 4'd0, 5'd0, 32'h0};
        tbl[6]  = '{1'b1, 5'd9, 1'b0, 4'd0, 32'h0,    4'd0, 1'b0, 32'h0,    4'd4, 4'd0, 5'd0, 32'h0};
        tbl[7]  = '{1'b0, 5'd0, 1'b1, 4'd4, 32'h44,   4'd4, 1'b1, 32'h44,   4'd5, 4'd0, 5'd0, 32'h0};
        tbl[8]  = '{1'b0, 5'd0, 1'b1, 4'd3, 32'h33,   4'd4, 1'b1, 32'h44,   4'd5, 4'd0, 5'd0, 32'h0};
        tbl[9]  = '{1'b0, 5'd0, 1'b1, 4'd2, 32'h22,   4'd3, 1'b1, 32'h33,   4'd5, 4'd0, 5'd0, 32'h0};
        tbl[10] = '{1'b0, 5'd0, 1'b0, 4'd0, 32'h0,    4'd2, 1'b1, 32'h22,   4'd5, 4'd2, 5'd7, 32'h22};
        tbl[11] = '{1'b0, 5'd0, 1'b0, 4'd0, 32'h0,    4'd0, 1'b0, 32'h0,    4'd5, 4'd3, 5'd8, 32'h33};
        tbl[12] = '{1'b0, 5'd0, 1'b0, 4'd0, 32'h0,    4'd0, 1'b0, 32'h0,    4'd5, 4'd4, 5'd9, 32'h44};
        tbl[13] = '{1'b0, 5'd0, 1'b0, 4'd0, 32'h0,    4'd0, 1'b0, 32'h0,    4'd5, 4'd0, 5'd0, 32'h0};

        for (int i = 0; i < 14; i++) begin
            idle_inputs();
            valid_from_issuer = tbl[i].iv;
            rd_from_issuer    = tbl[i].rd;
            valid_from_cdb    = tbl[i].cv;
            dest_from_cdb     = tbl[i].cd;
            value_from_cdb    = tbl[i].cval;
            qj_from_issuer    = tbl[i].qj;
            #1;
            chk($sformatf("tbl%0d.dest_to_issuer", i), {28'd0, dest_to_issuer}, {28'd0, tbl[i].exp_diss});
            chk($sformatf("tbl%0d.ready_j", i), {31'd0, ready_j_to_issuer}, {31'd0, tbl[i].exp_rj});
            chk($sformatf("tbl%0d.value_j", i), value_j_to_issuer, tbl[i].exp_vj);
            @(posedge clk);
            #1;
            chk_commit($sformatf("tbl%0d.commit", i), tbl[i].exp_cdest, tbl[i].exp_crd, tbl[i].exp_cval);
        end

        // full and wrap-around
        do_reset();
        for (int i = 1; i <= 15; i++) begin
            valid_from_issuer = 1'b1;
            rd_from_issuer    = 5'(i);
            #1;
            chk($sformatf("fill%0d.dest_to_issuer", i), {28'd0, dest_to_issuer}, i);
            chk($sformatf("fill%0d.full", i), {31'd0, full_to_issuer}, 32'd0);
            cyc();
        end
        idle_inputs();
        #1;
        chk("full.full", {31'd0, full_to_issuer}, 32'd1);
        chk("full.dest_wrap", {28'd0, dest_to_issuer}, 32'd1);
        valid_from_issuer = 1'b1;      // blocked while full
        valid_from_cdb    = 1'b1;
        dest_from_cdb     = 4'd1;
        value_from_cdb    = 32'hBEEF;
        cyc();
        idle_inputs();
        cyc();
        chk_commit("wrap.commit", 4'd1, 5'd1, 32'hBEEF);
        chk("wrap.full", {31'd0, full_to_issuer}, 32'd0);
        chk("wrap.dest_to_issuer", {28'd0, dest_to_issuer}, 32'd1);
        valid_from_issuer = 1'b1;
        rd_from_issuer    = 5'd3;
        cyc();
        idle_inputs();
        #1;
        chk("wrap.refull", {31'd0, full_to_issuer}, 32'd1);
        chk("wrap.dest_next", {28'd0, dest_to_issuer}, 32'd2);

        // mispredict with two younger entries
        do_reset();
        valid_from_issuer = 1'b1; rd_from_issuer = 5'd1; is_branch_from_issuer = 1'b1;
        pred_taken_from_issuer = 1'b0; alt_pc_from_issuer = 32'h40;
        cyc();
        is_branch_from_issuer = 1'b0; rd_from_issuer = 5'd2; alt_pc_from_issuer = '0;
        cyc();
        rd_from_issuer = 5'd3;
        cyc();
        idle_inputs();
        valid_from_cdb = 1'b1; dest_from_cdb = 4'd1; value_from_cdb = 32'h77; taken_from_cdb = 1'b1;
        cyc();
        idle_inputs();
        cyc();
        chk_commit("mispred.commit", 4'd1, 5'd1, 32'h77);
        chk("mispred.flush_early", {31'd0, reset_to_rob_bus}, 32'd0);
        chk("mispred.full_flushing", {31'd0, full_to_issuer}, 32'd1);
        valid_from_cdb = 1'b1; dest_from_cdb = 4'd2; value_from_cdb = 32'h55;  // ignored
        cyc();
        idle_inputs();
        chk("mispred.flush", {31'd0, reset_to_rob_bus}, 32'd1);
        chk("mispred.pc", pc_to_fetcher, 32'h40);
        chk_commit("mispred.idle", 4'd0, 5'd0, 32'd0);
        chk("mispred.dest_to_issuer", {28'd0, dest_to_issuer}, 32'd1);
        chk("mispred.full_after", {31'd0, full_to_issuer}, 32'd0);
        qj_from_issuer = 4'd2;
        #1;
        chk("mispred.lookup_cleared", {31'd0, ready_j_to_issuer}, 32'd0);
        cyc();
        chk("mispred.flush_one_cycle", {31'd0, reset_to_rob_bus}, 32'd0);
        chk_commit("mispred.no_commit", 4'd0, 5'd0, 32'd0);

        // reset wins over a pending flush
        do_reset();
        valid_from_issuer = 1'b1; rd_from_issuer = 5'd4; is_branch_from_issuer = 1'b1;
        pred_taken_from_issuer = 1'b1; alt_pc_from_issuer = 32'h80;
        cyc();
        idle_inputs();
        valid_from_cdb = 1'b1; dest_from_cdb = 4'd1; taken_from_cdb = 1'b0; value_from_cdb = 32'h9;
        cyc();
        idle_inputs();
        cyc();
        chk_commit("rstpri.commit", 4'd1, 5'd4, 32'h9);
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        chk("rstpri.no_flush", {31'd0, reset_to_rob_bus}, 32'd0);
        chk("rstpri.pc", pc_to_fetcher, 32'd0);
        cyc();
        chk("rstpri.no_flush_later", {31'd0, reset_to_rob_bus}, 32'd0);

        // randomized traffic against the model
        model_reset();
        for (int c = 0; c < 4000; c++) begin
            idle_inputs();
            rst = (c == 0) || ($urandom_range(0, 399) == 0);
            rdy = ($urandom_range(0, 7) != 0);
            valid_from_issuer      = ($urandom_range(0, 2) != 0);
            rd_from_issuer         = 5'($urandom_range(0, 31));
            is_branch_from_issuer  = ($urandom_range(0, 4) == 0);
            pred_taken_from_issuer = 1'($urandom_range(0, 1));
            alt_pc_from_issuer     = $urandom & 32'hFFFF_FFFC;
            valid_from_cdb         = ($urandom_range(0, 2) != 0);
            value_from_cdb         = $urandom;
            taken_from_cdb         = 1'($urandom_range(0, 1));
            if (rob.size() > 0 && $urandom_range(0, 3) != 0) begin
                idx = $urandom_range(0, rob.size() - 1);
                dest_from_cdb = rob[idx].tag;
            end else begin
                dest_from_cdb = 4'($urandom_range(0, 15));
            end
            qj_from_issuer = ($urandom_range(0, 3) == 0) ? dest_from_cdb : 4'($urandom_range(0, 15));
            qk_from_issuer = 4'($urandom_range(0, 15));
            #1;
            if (c != 0) begin
                model_lookup(qj_from_issuer, er, ev);
                model_lookup(qk_from_issuer, ek, evk);
                chk($sformatf("rnd%0d.dest_to_issuer", c), {28'd0, dest_to_issuer}, {28'd0, m_next});
                chk($sformatf("rnd%0d.full", c), {31'd0, full_to_issuer},
                    {31'd0, (rob.size() == 15) || m_pend});
                chk($sformatf("rnd%0d.ready_j", c), {31'd0, ready_j_to_issuer}, {31'd0, er});
                chk($sformatf("rnd%0d.value_j", c), value_j_to_issuer, ev);
                chk($sformatf("rnd%0d.ready_k", c), {31'd0, ready_k_to_issuer}, {31'd0, ek});
                chk($sformatf("rnd%0d.value_k", c), value_k_to_issuer, evk);
            end
            @(posedge clk);
            #1;
            model_edge();
            chk_commit($sformatf("rnd%0d.commit", c), m_cdest, m_crd, m_cval);
            chk($sformatf("rnd%0d.flush", c), {31'd0, reset_to_rob_bus}, {31'd0, m_rbus});
            if (m_rbus)
                chk($sformatf("rnd%0d.pc", c), pc_to_fetcher, m_pc);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
